// File: rtl/agc_gain_ctrl.sv
// agc_gain_ctrl: AGC gain scheduler.
// Tracks the peak sample magnitude over a window of 2^WIN_LOG2 accepted samples.
// In the one-cycle EVAL state it steps the gain down (attack) or up (release),
// using a target level with a hysteresis band and a hold-off after each attack.
// Ports:
//   clk, reset_not                 - clock, asynchronous active-low reset
//   enable                         - run control (low returns to IDLE)
//   smp_valid, smp_in              - sample strobe and signed 8-bit sample
//   target, hyst                   - target peak level and hysteresis half-band
//   atk_step, rel_step             - gain decrement / increment per window
//   freeze                         - only with AGC_FREEZE_EN: EVAL leaves gain and hold untouched
//   gain, gain_upd, peak, state    - gain, change pulse, running peak, FSM state
// Build option: define AGC_FREEZE_EN to add the freeze input.
module agc_gain_ctrl #(
  parameter int unsigned WIN_LOG2  = 4,
  parameter int unsigned HOLD_WIN  = 4,
  parameter logic [7:0]  GAIN_INIT = 8'h40,
  parameter logic [7:0]  GAIN_MIN  = 8'h01
) (
  input  logic       clk,
  input  logic       reset_not,
  input  logic       enable,
  input  logic       smp_valid,
  input  logic [7:0] smp_in,
  input  logic [7:0] target,
  input  logic [3:0] hyst,
  input  logic [3:0] atk_step,
  input  logic [3:0] rel_step,
`ifdef AGC_FREEZE_EN
  input  logic       freeze,
`endif
  output logic [7:0] gain,
  output logic       gain_upd,
  output logic [7:0] peak,
  output logic [1:0] state
);

  localparam int unsigned CNT_W  = WIN_LOG2 + 1;
  localparam int unsigned HOLD_W = (HOLD_WIN > 1) ? $clog2(HOLD_WIN + 1) : 1;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << WIN_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    EVAL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        peak_q, peak_d;
  logic [7:0]        gain_q, gain_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              upd_q, upd_d;

  logic       frz;
  logic [7:0] mag;
  logic [8:0] hi;
  logic [7:0] lo;
  logic       lo_ok;
  logic       loud;
  logic       quiet;
  logic [8:0] dec_floor;
  logic [7:0] gain_dec;
  logic [8:0] inc_sum;
  logic [7:0] gain_inc;

`ifdef AGC_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif

  always_comb begin
    // two's-complement negate; -128 wraps to 8'h80 which reads as 128 unsigned
    mag       = smp_in[7] ? (~smp_in + 8'd1) : smp_in;
    hi        = {1'b0, target} + {5'b0, hyst};
    lo_ok     = (target >= {4'b0, hyst});
    lo        = target - {4'b0, hyst};
    loud      = ({1'b0, peak_q} > hi);
    quiet     = lo_ok && (peak_q < lo);
    // gain - atk_step >= GAIN_MIN  <=>  gain >= atk_step + GAIN_MIN, avoids signed math
    dec_floor = {5'b0, atk_step} + {1'b0, GAIN_MIN};
    gain_dec  = ({1'b0, gain_q} < dec_floor) ? GAIN_MIN : (gain_q - {4'b0, atk_step});
    inc_sum   = {1'b0, gain_q} + {5'b0, rel_step};
    gain_inc  = inc_sum[8] ? 8'hFF : inc_sum[7:0];
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable) state_d = ACQ;
      ACQ: begin
        if (!enable)                             state_d = IDLE;
        else if (smp_valid && cnt_q == WIN_LAST) state_d = EVAL;
      end
      EVAL:    state_d = enable ? ACQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    peak_d = peak_q;
    gain_d = gain_q;
    hold_d = hold_q;
    upd_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        peak_d = '0;
      end
      ACQ: begin
        if (!enable) begin
          cnt_d  = '0;
          peak_d = '0;
        end else if (smp_valid) begin
          cnt_d  = cnt_q + CNT_W'(1);
          peak_d = (cnt_q == '0 || mag > peak_q) ? mag : peak_q;
        end
      end
      EVAL: begin
        if (enable) begin
          if (!frz) begin
            if (loud) begin
              gain_d = gain_dec;
              hold_d = HOLD_W'(HOLD_WIN);
            end else if (quiet) begin
              if (hold_q == '0) gain_d = gain_inc;
              else              hold_d = hold_q - HOLD_W'(1);
            end else if (hold_q != '0) begin
              hold_d = hold_q - HOLD_W'(1);
            end
          end
          // a sample arriving during EVAL opens the next window
          if (smp_valid) begin
            cnt_d  = CNT_W'(1);
            peak_d = mag;
          end else begin
            cnt_d  = '0;
            peak_d = '0;
          end
        end else begin
          cnt_d  = '0;
          peak_d = '0;
        end
        upd_d = (gain_d != gain_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      cnt_q  <= '0;
      peak_q <= '0;
      gain_q <= GAIN_INIT;
      hold_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
      gain_q <= gain_d;
      hold_q <= hold_d;
      upd_q  <= upd_d;
    end
  end

  assign gain     = gain_q;
  assign gain_upd = upd_q;
  assign peak     = peak_q;
  assign state    = state_q;

endmodule
